// File: rtl/phy_pkg.sv
// phy_pkg: shared constants and state encoding for the phy receive path
package phy_pkg;
  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] COMMA_BC = 8'hBC;
  typedef enum logic [1:0] {SEARCH = 2'd0, LOCKING = 2'd1, ACTIVE = 2'd2} state_t;
endpackage

// File: rtl/serial_paralelo_rx_comma_detector.sv
// comma_detector: serial history register plus sliding comma compare
//   clk_8f   bit clock
//   reset    asynchronous active-high reset
//   data_in  serial bit, MSB first
//   cand     the last 8 bits received, newest in bit 0
//   is_comma cand equals COMMA
module comma_detector
  import phy_pkg::*;
#(
  parameter logic [BYTE_W-1:0] COMMA = COMMA_BC
) (
  input  logic              clk_8f,
  input  logic              reset,
  input  logic              data_in,
  output logic [BYTE_W-1:0] cand,
  output logic              is_comma
);
  // The oldest bit of the 8-bit window falls out of cand on the next shift,
  // so only the seven most recent past bits need storing.
  logic [BYTE_W-2:0] shift;
  assign cand = {shift, data_in};
  assign is_comma = cand == COMMA;
  always_ff @(posedge clk_8f or posedge reset)
    if (reset) shift <= '0;
    else shift <= cand[BYTE_W-2:0];
endmodule

// File: rtl/serial_paralelo_rx.sv
// serial_paralelo_rx: comma-aligned MSB-first deserialiser with lock FSM
//   clk_8f       bit clock, 8x byte rate
//   reset        asynchronous active-high reset
//   data_in      serial bit, MSB of each byte first
//   data_out     last received data byte (0 for a comma)
//   valid_out    data_out holds a non-comma byte
//   byte_strobe  one-cycle pulse per aligned byte boundary
//   active       link locked
//   rx_byte_cnt  saturating count of valid bytes, only with SP_RX_BYTE_CNT_EN
module serial_paralelo_rx
  import phy_pkg::*;
#(
  parameter logic [BYTE_W-1:0] COMMA    = COMMA_BC,
  parameter int                BC_COUNT = 4
) (
  input  logic              clk_8f,
  input  logic              reset,
  input  logic              data_in,
  output logic [BYTE_W-1:0] data_out,
  output logic              valid_out,
  output logic              byte_strobe,
`ifdef SP_RX_BYTE_CNT_EN
  output logic [7:0]        rx_byte_cnt,
`endif
  output logic              active
);
  state_t            state;
  logic [2:0]        bit_cnt;
  logic [3:0]        bc_cnt;
  logic [BYTE_W-1:0] cand;
  logic              is_comma;
  logic              boundary;
  logic              lock_done;
  comma_detector #(.COMMA(COMMA)) u_det (
    .clk_8f  (clk_8f),
    .reset   (reset),
    .data_in (data_in),
    .cand    (cand),
    .is_comma(is_comma)
  );
  assign boundary = bit_cnt == 3'd7;
  assign lock_done = is_comma && ({1'b0, bc_cnt} + 5'd1 == 5'(BC_COUNT));
  assign active = state == ACTIVE;
  // bit_cnt is parked at 0 while searching so the first aligned boundary
  // lands 8 bits after the comma that started the lock attempt.
  always_ff @(posedge clk_8f or posedge reset)
    if (reset) begin
      state       <= SEARCH;
      bit_cnt     <= '0;
      bc_cnt      <= '0;
      data_out    <= '0;
      valid_out   <= 1'b0;
      byte_strobe <= 1'b0;
    end else begin
      byte_strobe <= boundary && state != SEARCH;
      bit_cnt     <= state == SEARCH ? 3'd0 : bit_cnt + 3'd1;
      case (state)
        SEARCH: if (is_comma) begin
          bc_cnt <= 4'd1;
          state  <= BC_COUNT == 1 ? ACTIVE : LOCKING;
        end
        LOCKING: if (boundary) begin
          bc_cnt <= is_comma ? bc_cnt + 4'd1 : 4'd0;
          state  <= !is_comma ? SEARCH : lock_done ? ACTIVE : LOCKING;
        end
        ACTIVE: if (boundary) begin
          valid_out <= !is_comma;
          data_out  <= is_comma ? '0 : cand;
        end
        default: state <= SEARCH;
      endcase
    end
`ifdef SP_RX_BYTE_CNT_EN
  always_ff @(posedge clk_8f or posedge reset)
    if (reset) rx_byte_cnt <= '0;
    else if (state == ACTIVE && boundary && !is_comma && rx_byte_cnt != 8'hFF)
      rx_byte_cnt <= rx_byte_cnt + 8'd1;
`endif
endmodule

// File: tb/tb_serial_paralelo_rx.sv
// tb_serial_paralelo_rx: scoreboard bench for the comma-aligned deserialiser
module tb_serial_paralelo_rx;
  logic       clk_8f = 1'b0;
  logic       reset = 1'b1;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;
`ifdef SP_RX_BYTE_CNT_EN
  logic [7:0] rx_byte_cnt;
`endif
  int         tests = 0;
  int         fails = 0;
  logic [8:0] exp_q[$];
  logic [8:0] last_exp = 9'h000;

  serial_paralelo_rx dut (
    .clk_8f     (clk_8f),
    .reset      (reset),
    .data_in    (data_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .byte_strobe(byte_strobe),
`ifdef SP_RX_BYTE_CNT_EN
    .rx_byte_cnt(rx_byte_cnt),
`endif
    .active     (active)
  );

  always #5 clk_8f = ~clk_8f;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send_bit(input logic b);
    data_in = b;
    @(negedge clk_8f);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  // Aligned byte while ACTIVE: queue the expected output, check the
  // previous output is still held mid-byte and the strobe lands on bit 0.
  task automatic send_data(input logic [7:0] v);
    logic [8:0] e;
    e = v == 8'hBC ? 9'h000 : {1'b1, v};
    exp_q.push_back(e);
    for (int i = 7; i >= 0; i--) begin
      send_bit(v[i]);
      if (i == 3) begin
        chk("hold_out", {valid_out, data_out}, last_exp);
        chk("strobe_mid", byte_strobe, 0);
      end
    end
    chk("strobe_edge", byte_strobe, 1);
    last_exp = e;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk_8f);
    reset = 1'b0;
    last_exp = 9'h000;
  endtask

  task automatic lock4();
    repeat (3) send_byte(8'hBC);
    chk("lock_pre", active, 0);
    send_byte(8'hBC);
    chk("lock_post", active, 1);
  endtask

  // Monitor: every strobe after lock presents one byte to the scoreboard.
  initial begin
    logic prev = 1'b0;
    forever begin
      @(negedge clk_8f);
      if (byte_strobe && prev) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_unexpected: got %0h expected none", {valid_out, data_out});
        end else chk("sb_byte", {valid_out, data_out}, exp_q.pop_front());
      end
      prev = active;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk_8f);
    // reset held: random bits must not move anything
    for (int i = 0; i < 16; i++) send_bit(1'($urandom));
    chk("rst_data", data_out, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_strobe", byte_strobe, 0);
    chk("rst_active", active, 0);
    reset = 1'b0;
    repeat (4) send_byte(8'h00);
    chk("zeros_active", active, 0);
    chk("zeros_valid", valid_out, 0);

    // lock from idle: 3 stray bits then 4 commas, lock on bit 35
    do_reset();
    repeat (3) send_bit(1'($urandom));
    send_byte(8'hBC);
    chk("search_no_strobe", byte_strobe, 0);
    send_byte(8'hBC);
    chk("lock_strobe2", byte_strobe, 1);
    send_byte(8'hBC);
    for (int i = 7; i >= 1; i--) send_bit(1'((8'hBC >> i) & 8'h01));
    chk("active_early", active, 0);
    send_bit(1'b0);
    chk("active_rise", active, 1);
    chk("lock_strobe4", byte_strobe, 1);
    chk("lock_valid", valid_out, 0);

    // data after lock
    send_data(8'hA5);
    send_data(8'hBC);
    send_data(8'h3C);
    send_data(8'h00);

    // failed lock: 0x55 breaks the run of commas
    do_reset();
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'h55);
    chk("fail_active", active, 0);
    lock4();
    send_data(8'h7E);

    // asynchronous reset between edges while active
    send_data(8'hC3);
    send_bit(1'b1);
    send_bit(1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_data", data_out, 0);
    chk("arst_valid", valid_out, 0);
    chk("arst_active", active, 0);
    @(negedge clk_8f);
    reset = 1'b0;
    last_exp = 9'h000;
    lock4();
    send_data(8'h5A);

`ifdef SP_RX_BYTE_CNT_EN
    do_reset();
    lock4();
    chk("cnt_zero", rx_byte_cnt, 0);
    repeat (10) send_data(8'h11);
    repeat (5) send_data(8'hBC);
    chk("cnt_10", rx_byte_cnt, 10);
    repeat (290) send_data(8'h11);
    chk("cnt_sat", rx_byte_cnt, 8'hFF);
`endif

    @(negedge clk_8f);
    chk("sb_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/serial_paralelo_rx.md
Name: serial_paralelo_rx

Overview:
- Receive-side counterpart of the phy_tx serialiser.
- Deserialises an MSB-first bit stream at clk_8f into bytes.
- Acquires byte alignment by detecting the idle comma (0xBC), and declares the link active after BC_COUNT consecutive aligned commas.
- Once active, presents data bytes with valid to the phy_rx pipeline flops; commas are reported as idle (valid low).

Parameters:
- COMMA, 8'hBC, idle/alignment character.
- BC_COUNT, 4, consecutive aligned commas (including the first) required to enter ACTIVE; legal range 1..15.

Ports:
- clk_8f  input  1  bit clock, 8x byte rate; all logic on its rising edge.
- reset  input  1  asynchronous, active-high.
- data_in  input  1  serial bit, MSB of each byte first.
- data_out  output  8  last received data byte.
- valid_out  output  1  data_out holds a data (non-comma) byte.
- byte_strobe  output  1  one-cycle pulse per assembled byte while aligned.
- active  output  1  link locked (state == ACTIVE).

Behaviour:
- Reset (async, active-high) clears shift register, bit_cnt(3b), bc_cnt(4b), data_out, valid_out, byte_strobe and active to 0; state goes to SEARCH. Reset asserted mid-byte or mid-lock discards all progress.
- Shift register: shift <= {shift[6:0], data_in} every cycle in every state.
- Candidate byte: cand = {shift[6:0], data_in}.
- SEARCH:
  - Sliding compare every cycle.
  - On cand == COMMA: bit_cnt <= 0, bc_cnt <= 1, go to LOCKING. If BC_COUNT == 1, go directly to ACTIVE.
  - data_out, valid_out and byte_strobe stay 0.
- LOCKING and ACTIVE: bit_cnt increments every cycle and wraps 7->0. Byte boundary is bit_cnt == 7, with the byte equal to cand.
- LOCKING, at a boundary:
  - cand == COMMA and bc_cnt+1 == BC_COUNT: go to ACTIVE.
  - cand == COMMA otherwise: bc_cnt++.
  - cand != COMMA: bc_cnt <= 0, go to SEARCH. The sliding search resumes on the next cycle using the retained shift register.
  - byte_strobe pulses at every boundary; valid_out stays 0.
- ACTIVE, at a boundary:
  - byte_strobe <= 1.
  - cand == COMMA: valid_out <= 0, data_out <= 0.
  - Otherwise: valid_out <= 1, data_out <= cand.
  - Outputs are held for 8 cycles until the next boundary. byte_strobe is 0 off-boundary.
- Latency: the last bit of a byte is sampled at edge N; data_out, valid_out and byte_strobe are visible after edge N (1 cycle).
- active is asserted on the edge that completes lock and stays high until reset. There is no loss-of-lock detection.
- A comma arriving in ACTIVE at a non-aligned offset is treated as ordinary data bits; there is no realignment.

Optional Feature:
- Macro: SP_RX_BYTE_CNT_EN.
- Defined:
  - Adds output rx_byte_cnt [7:0].
  - Counts bytes presented with valid_out = 1 in ACTIVE.
  - Saturates at 8'hFF and resets to 0.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Decomposition:
- Package phy_pkg:
  - COMMA_BC = 8'hBC.
  - state encoding localparams SEARCH = 2'd0, LOCKING = 2'd1, ACTIVE = 2'd2.
  - BYTE_W = 8.
- One sub-module is natural: comma_detector, holding the 8-bit shift register plus the cand == COMMA compare. The FSM and counters stay in the top.

Test Plan:
- Reset: hold reset high, drive random bits -> all outputs 0, active 0. Release reset and send 0x00 forever -> active stays 0.
- Lock from idle: 3 random bits, then 4x 0xBC -> active rises one cycle after the last bit of the 4th comma, exactly 3 bits + 32 cycles after start. byte_strobe pulses every 8 cycles from the first aligned boundary.
- Data after lock: 4x 0xBC, then 0xA5, 0xBC, 0x3C -> data_out/valid_out = A5/1, 00/0, 3C/1, each 1 cycle after the byte's last bit and held 8 cycles.
- Failed lock: 0xBC, 0xBC, 0x55, then 4x 0xBC -> returns to SEARCH after 0x55; active rises only after the later 4 commas.
- Async reset mid-data: assert reset between clock edges in ACTIVE -> outputs clear immediately without waiting for a clock edge. After release, relock requires 4 commas.
- With SP_RX_BYTE_CNT_EN: lock, then 300 data bytes of 0x11 -> rx_byte_cnt saturates at 0xFF. Interleaved commas do not increment the counter.
